// File: rtl/spi_reply_encoder.sv
// Frames reply-FIFO contents as SOF, ADDR, N, payload[0..N-1] and, when
// SPI_REPLY_CSUM_EN is defined, a trailing XOR checksum of ADDR, N and payload.
module spi_reply_encoder #(
    parameter logic [7:0] SOF  = 8'hA5,
    parameter logic [7:0] ADDR = 8'h01
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       have_msg,
    input  logic [7:0] len,
    input  logic [7:0] in_data,
    output logic       rdreq,
    input  logic       tx_ready,
    output logic [7:0] out_data,
    output logic       out_ena,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE,
        HDR_SOF,
        HDR_ADDR,
        HDR_LEN,
        RD,
        LAT,
        DATA
`ifdef SPI_REPLY_CSUM_EN
        ,
        CSUM
`endif
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  out_data_q, out_data_d;
    logic [6:0]  cnt_q, cnt_d;
    logic [6:0]  n_sample;
    logic        emit_state;
    logic        xfer;
    logic        len_unused;

    // Only the low six bits of the fill level carry the byte count.
    assign len_unused = &len[7:6];
    assign n_sample   = (len[5:0] == 6'd0) ? 7'd64 : {1'b0, len[5:0]};

`ifdef SPI_REPLY_CSUM_EN
    logic [7:0] csum_q, csum_d;
`endif

    always_comb begin
        emit_state = 1'b0;
        case (state_q)
            HDR_SOF, HDR_ADDR, HDR_LEN, DATA: emit_state = 1'b1;
`ifdef SPI_REPLY_CSUM_EN
            CSUM:                             emit_state = 1'b1;
`endif
            default:                          emit_state = 1'b0;
        endcase
    end

    assign xfer = emit_state && tx_ready;

    always_comb begin
        state_d    = state_q;
        out_data_d = out_data_q;
        cnt_d      = cnt_q;
`ifdef SPI_REPLY_CSUM_EN
        csum_d     = csum_q;
`endif
        case (state_q)
            IDLE: begin
                if (have_msg) begin
                    state_d    = HDR_SOF;
                    out_data_d = SOF;
                    cnt_d      = n_sample;
`ifdef SPI_REPLY_CSUM_EN
                    csum_d     = ADDR ^ {1'b0, n_sample};
`endif
                end
            end
            HDR_SOF: begin
                if (xfer) begin
                    state_d    = HDR_ADDR;
                    out_data_d = ADDR;
                end
            end
            HDR_ADDR: begin
                if (xfer) begin
                    state_d    = HDR_LEN;
                    out_data_d = {1'b0, cnt_q};
                end
            end
            HDR_LEN: begin
                if (xfer) begin
                    state_d = RD;
                end
            end
            RD: begin
                state_d = LAT;
            end
            LAT: begin
                // FIFO q is valid here, one cycle after the read strobe.
                state_d    = DATA;
                out_data_d = in_data;
`ifdef SPI_REPLY_CSUM_EN
                csum_d     = csum_q ^ in_data;
`endif
            end
            DATA: begin
                if (xfer) begin
                    cnt_d = cnt_q - 7'd1;
                    if (cnt_q == 7'd1) begin
`ifdef SPI_REPLY_CSUM_EN
                        state_d    = CSUM;
                        out_data_d = csum_q;
`else
                        state_d    = IDLE;
`endif
                    end else begin
                        state_d = RD;
                    end
                end
            end
`ifdef SPI_REPLY_CSUM_EN
            CSUM: begin
                if (xfer) begin
                    state_d = IDLE;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            out_data_q <= 8'h00;
            cnt_q      <= 7'd0;
`ifdef SPI_REPLY_CSUM_EN
            csum_q     <= 8'h00;
`endif
        end else begin
            state_q    <= state_d;
            out_data_q <= out_data_d;
            cnt_q      <= cnt_d;
`ifdef SPI_REPLY_CSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    // Reset wins in its own cycle: no strobe escapes while rst is high.
    assign out_ena  = xfer && !rst;
    assign rdreq    = (state_q == RD) && !rst;
    assign busy     = (state_q != IDLE);
    assign out_data = out_data_q;

endmodule
